// File: rtl/difftest_multicore_monitor_if.sv
// Core-facing bundle of the multi-core DiffTest monitor: per-core step/exit,
// per-core UART streams and the merged UART output stream.
interface difftest_multicore_monitor_if #(
  parameter int NUM_CORES  = 2,
  parameter int STEP_WIDTH = 8
);
  logic [NUM_CORES-1:0][STEP_WIDTH-1:0] core_step;
  logic [NUM_CORES-1:0][63:0]           core_exit;
  logic [NUM_CORES-1:0]                 core_uart_valid;
  logic [NUM_CORES-1:0][7:0]            core_uart_ch;
  logic [NUM_CORES-1:0]                 core_uart_ready;
  logic                                 uart_out_valid;
  logic [7:0]                           uart_out_ch;
  logic                                 uart_out_ready;

  // Harness / core side
  modport master (
    output core_step, core_exit, core_uart_valid, core_uart_ch, uart_out_ready,
    input  core_uart_ready, uart_out_valid, uart_out_ch
  );

  // Monitor side
  modport slave (
    input  core_step, core_exit, core_uart_valid, core_uart_ch, uart_out_ready,
    output core_uart_ready, uart_out_valid, uart_out_ch
  );
endinterface

// File: rtl/difftest_multicore_monitor.sv
// Run-control monitor for multi-core DiffTest builds: per-core stuck/exit
// detection, global cycle limit, merged UART FIFO and a sticky pass/fail
// verdict with cause, core index and exit code.

// Per-core watcher: sticky exit flag and saturating no-step timer.
module difftest_core_watch #(
  parameter int STEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [63:0]           exit_code,
  input  logic [CNT_WIDTH-1:0]  stuck_limit,
  output logic                  exited,
  output logic                  exiting,
  output logic                  exit_err,
  output logic                  stuck
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] timer;

  assign exiting  = &exit_code;
  assign exit_err = (exit_code != '0) && !exiting;
  assign stuck    = (stuck_limit != '0) && (timer >= stuck_limit);

  // Exit flag and no-step timer only evolve while the monitor is running
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exited <= 1'b0;
      timer  <= '0;
    end else if (run) begin
      if (exiting) exited <= 1'b1;
      if (!exited) begin
        if (step != '0)       timer <= '0;
        else if (timer != '1) timer <= timer + ONE;
      end
    end
  end
endmodule

module difftest_multicore_monitor #(
  parameter int NUM_CORES  = 2,
  parameter int STEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 64,
  parameter int UART_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] cfg_max_cycles,
  input  logic [CNT_WIDTH-1:0] cfg_stuck_limit,
  difftest_multicore_monitor_if.slave bus,
  input  logic                 perf_clean_req,
  output logic                 perf_clean,
  output logic                 perf_dump,
  output logic                 done,
  output logic                 fail,
  output logic [1:0]           fail_cause,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] fail_core,
  output logic [63:0]          exit_code,
  output logic [CNT_WIDTH-1:0] n_cycles
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(UART_DEPTH);
  localparam logic [AW:0]          DEPTH   = (AW+1)'(UART_DEPTH);
  localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [2:0] S_RUN        = 3'd0;
  localparam logic [2:0] S_DRAIN_PASS = 3'd1;
  localparam logic [2:0] S_DRAIN_FAIL = 3'd2;
  localparam logic [2:0] S_DONE       = 3'd3;
  localparam logic [2:0] S_FAIL       = 3'd4;

  logic [2:0]           state;
  logic                 run;
  logic [NUM_CORES-1:0] exited, exiting, exit_err, stuck;
  logic                 ev_fail, ev_pass;
  logic [1:0]           ev_cause;
  logic [IW-1:0]        ev_core;
  logic [63:0]          ev_code;
  logic [IW-1:0]        rr_ptr, gnt;
  logic                 gnt_vld, accept, pop;
  logic [7:0]           mem [UART_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 req_q;

  assign run  = (state == S_RUN);
  assign done = (state == S_DONE);
  assign fail = (state == S_FAIL);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    difftest_core_watch #(.STEP_WIDTH(STEP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_watch (
      .clock      (clock),
      .reset_n    (reset_n),
      .run        (run),
      .step       (bus.core_step[i]),
      .exit_code  (bus.core_exit[i]),
      .stuck_limit(cfg_stuck_limit),
      .exited     (exited[i]),
      .exiting    (exiting[i]),
      .exit_err   (exit_err[i]),
      .stuck      (stuck[i])
    );
  end

  // Event resolution: later assignments override, so the highest-priority
  // cause and the lowest core index win.
  always_comb begin
    ev_fail  = 1'b0;
    ev_cause = 2'd0;
    ev_core  = '0;
    ev_code  = '0;
    if (cfg_max_cycles != '0 && n_cycles >= cfg_max_cycles) begin
      ev_fail  = 1'b1;
      ev_cause = 2'd3;
    end
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (stuck[i]) begin
        ev_fail  = 1'b1;
        ev_cause = 2'd2;
        ev_core  = IW'(i);
        ev_code  = '0;
      end
    end
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (exit_err[i]) begin
        ev_fail  = 1'b1;
        ev_cause = 2'd1;
        ev_core  = IW'(i);
        ev_code  = bus.core_exit[i];
      end
    end
    ev_pass = &(exited | exiting);
  end

  // Round-robin grant: first valid core at or after the pointer
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NUM_CORES-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (bus.core_uart_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = IW'(idx);
      end
    end
  end

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == DEPTH);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign accept     = gnt_vld && !fifo_full && run;
  assign pop        = !fifo_empty && bus.uart_out_ready;

  assign bus.uart_out_valid = !fifo_empty;
  assign bus.uart_out_ch    = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // One-hot ready to the granted core only when its char is taken
  always_comb begin
    bus.core_uart_ready = '0;
    if (accept) bus.core_uart_ready[gnt] = 1'b1;
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= bus.core_uart_ch[gnt];
  end

  // FIFO pointers and round-robin pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        rr_ptr <= (int'(gnt) == NUM_CORES-1) ? '0 : gnt + IW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Verdict FSM; cause/core/code latch only on the RUN exit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_RUN;
      fail_cause <= '0;
      fail_core  <= '0;
      exit_code  <= '0;
      perf_dump  <= 1'b0;
    end else begin
      perf_dump <= run && (ev_fail || ev_pass);
      case (state)
        S_RUN: begin
          if (ev_fail) begin
            state      <= S_DRAIN_FAIL;
            fail_cause <= ev_cause;
            fail_core  <= ev_core;
            exit_code  <= ev_code;
          end else if (ev_pass) begin
            state <= S_DRAIN_PASS;
          end
        end
        S_DRAIN_PASS: if (fifo_empty) state <= S_DONE;
        S_DRAIN_FAIL: if (fifo_empty) state <= S_FAIL;
        default: ;
      endcase
    end
  end

  // Saturating cycle counter and perf-clean edge detector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_cycles   <= '0;
      req_q      <= 1'b0;
      perf_clean <= 1'b0;
    end else begin
      if (n_cycles != '1) n_cycles <= n_cycles + CNT_ONE;
      req_q      <= perf_clean_req;
      perf_clean <= perf_clean_req && !req_q;
    end
  end
endmodule

// File: tb/tb_difftest_multicore_monitor.sv
// Self-checking bench for difftest_multicore_monitor: randomized scenarios
// checked against expectations derived from the event/timing rules.
`timescale 1ns/1ps
module tb_difftest_multicore_monitor;
  localparam int NC = 2;
  localparam int SW = 8;
  localparam int CW = 64;
  localparam int UD = 4;
  localparam logic [63:0] ALL1 = '1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] cfg_max_cycles, cfg_stuck_limit;
  logic          perf_clean_req, perf_clean, perf_dump, done, fail;
  logic [1:0]    fail_cause;
  logic [0:0]    fail_core;
  logic [63:0]   exit_code;
  logic [CW-1:0] n_cycles;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  difftest_multicore_monitor_if #(.NUM_CORES(NC), .STEP_WIDTH(SW)) bus ();

  difftest_multicore_monitor #(
    .NUM_CORES(NC), .STEP_WIDTH(SW), .CNT_WIDTH(CW), .UART_DEPTH(UD)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_max_cycles(cfg_max_cycles), .cfg_stuck_limit(cfg_stuck_limit),
    .bus(bus),
    .perf_clean_req(perf_clean_req), .perf_clean(perf_clean), .perf_dump(perf_dump),
    .done(done), .fail(fail), .fail_cause(fail_cause), .fail_core(fail_core),
    .exit_code(exit_code), .n_cycles(n_cycles)
  );

  task automatic tick();
    @(posedge clock); #1; cyc++;
  endtask

  task automatic idle_inputs();
    cfg_max_cycles = '0; cfg_stuck_limit = '0; perf_clean_req = 1'b0;
    bus.uart_out_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      bus.core_step[i] = SW'($urandom_range(1, 255));
      bus.core_exit[i] = '0;
      bus.core_uart_valid[i] = 1'b0;
      bus.core_uart_ch[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    @(posedge clock); #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    int k;
    idle_inputs();
    reset_n = 1'b0;
    #3;
    vectors++;
    if ({done, fail, perf_dump, perf_clean, bus.uart_out_valid} !== 5'b0 || fail_cause !== 2'd0 ||
        exit_code !== 64'd0 || n_cycles !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got done=%b fail=%b dump=%b clean=%b ovld=%b cause=%0d code=%h ncyc=%0d, want all 0",
               done, fail, perf_dump, perf_clean, bus.uart_out_valid, fail_cause, exit_code, n_cycles);
    end
    do_reset();
    k = $urandom_range(3, 20);
    repeat (k) tick();
    vectors++;
    if (n_cycles !== CW'(k)) begin
      miscompares++; $display("FAIL n_cycles_count: got %0d want %0d", n_cycles, k);
    end
  endtask

  // Two cores exit normally; the earlier one only pulses its all-ones code
  task automatic test_pass();
    int t0, t1, tp;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      t0 = $urandom_range(2, 15);
      t1 = (rep == 2) ? t0 : $urandom_range(2, 15);
      tp = (t0 > t1) ? t0 : t1;
      for (int c = 0; c < tp + 5; c++) begin
        bus.core_exit[0] = ((cyc == t0) || (cyc > t0 && t0 >= t1)) ? ALL1 : 64'd0;
        bus.core_exit[1] = ((cyc == t1) || (cyc > t1 && t1 >= t0)) ? ALL1 : 64'd0;
        tick();
        vectors++;
        if (perf_dump !== (cyc == tp + 1) || done !== (cyc >= tp + 2) || fail !== 1'b0) begin
          miscompares++;
          $display("FAIL pass_seq: cyc=%0d got dump=%b done=%b fail=%b want dump=%b done=%b fail=0 (t0=%0d t1=%0d)",
                   cyc, perf_dump, done, fail, cyc == tp + 1, cyc >= tp + 2, t0, t1);
        end
      end
    end
  endtask

  // Exit error on core1 in the same cycle core0 becomes stuck
  task automatic test_exit_err();
    int L;
    logic [63:0] code;
    do_reset();
    L = $urandom_range(3, 8);
    cfg_stuck_limit = CW'(L);
    code = {$urandom, $urandom};
    if (code == 64'd0 || code == ALL1) code = 64'h5;
    for (int c = 0; c < L + 5; c++) begin
      bus.core_step[0] = '0;
      bus.core_step[1] = SW'($urandom_range(1, 255));
      bus.core_exit[1] = (cyc == L) ? code : ((cyc > L) ? {$urandom, $urandom} : 64'd0);
      tick();
      vectors++;
      if (cyc <= L) begin
        if (fail_cause !== 2'd0) begin
          miscompares++; $display("FAIL err_early: cyc=%0d cause=%0d want 0", cyc, fail_cause);
        end
      end else if (fail_cause !== 2'd1 || fail_core !== 1'b1 || exit_code !== code || fail !== (cyc >= L + 2)) begin
        miscompares++;
        $display("FAIL err_latch: cyc=%0d got cause=%0d core=%0d code=%h fail=%b want 1/1/%h/%b",
                 cyc, fail_cause, fail_core, exit_code, fail, code, cyc >= L + 2);
      end
    end
  endtask

  // Stuck detection: core0 only, core1 only, then both (lowest index wins)
  task automatic test_stuck();
    int L, tl, ec;
    logic [1:0] m;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      L  = $urandom_range(2, 8);
      tl = $urandom_range(1, 6);
      m  = (rep == 0) ? 2'b01 : (rep == 1) ? 2'b10 : 2'b11;
      ec = m[0] ? 0 : 1;
      cfg_stuck_limit = CW'(L);
      for (int c = 0; c < tl + L + 6; c++) begin
        for (int i = 0; i < NC; i++)
          bus.core_step[i] = (m[i] && cyc > tl) ? '0 : SW'($urandom_range(1, 255));
        tick();
        vectors++;
        if (cyc >= tl + L + 2) begin
          if (fail_cause !== 2'd2 || fail_core !== 1'(ec) || exit_code !== 64'd0 || fail !== (cyc >= tl + L + 3)) begin
            miscompares++;
            $display("FAIL stuck_latch: cyc=%0d got cause=%0d core=%0d code=%h fail=%b want 2/%0d/0/%b (L=%0d tl=%0d)",
                     cyc, fail_cause, fail_core, exit_code, fail, ec, cyc >= tl + L + 3, L, tl);
          end
        end else if (fail_cause !== 2'd0 || fail !== 1'b0) begin
          miscompares++;
          $display("FAIL stuck_early: cyc=%0d cause=%0d fail=%b want 0/0 (L=%0d tl=%0d)", cyc, fail_cause, fail, L, tl);
        end
      end
    end
  endtask

  task automatic test_max_cycles();
    int M;
    do_reset();
    M = $urandom_range(20, 100);
    cfg_max_cycles = CW'(M);
    for (int c = 0; c < M + 4; c++) begin
      for (int i = 0; i < NC; i++) bus.core_step[i] = SW'($urandom_range(0, 255));
      tick();
      vectors++;
      if (fail_cause !== ((cyc >= M + 1) ? 2'd3 : 2'd0) || fail !== (cyc >= M + 2) ||
          exit_code !== 64'd0 || fail_core !== 1'b0) begin
        miscompares++;
        $display("FAIL max_cycles: cyc=%0d got cause=%0d fail=%b code=%h core=%0d (M=%0d)",
                 cyc, fail_cause, fail, exit_code, fail_core, M);
      end
    end
    // Both limits disabled: nothing may fire even with every core idle
    do_reset();
    for (int i = 0; i < NC; i++) bus.core_step[i] = '0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c % 250 == 0) begin
        vectors++;
        if (fail_cause !== 2'd0 || fail !== 1'b0 || done !== 1'b0 || n_cycles !== CW'(c)) begin
          miscompares++;
          $display("FAIL unlimited: cyc=%0d cause=%0d fail=%b done=%b ncyc=%0d want 0/0/0/%0d",
                   cyc, fail_cause, fail, done, n_cycles, c);
        end
      end
    end
  endtask

  task automatic test_perf_clean();
    int r1, r2, h;
    do_reset();
    r1 = $urandom_range(2, 10);
    h  = $urandom_range(1, 5);
    r2 = r1 + h + $urandom_range(2, 5);
    for (int c = 0; c < r2 + h + 4; c++) begin
      perf_clean_req = (cyc >= r1 && cyc < r1 + h) || (cyc >= r2 && cyc < r2 + h);
      tick();
      vectors++;
      if (perf_clean !== ((cyc == r1 + 1) || (cyc == r2 + 1))) begin
        miscompares++;
        $display("FAIL perf_clean: cyc=%0d got %b (r1=%0d r2=%0d h=%0d)", cyc, perf_clean, r1, r2, h);
      end
    end
  endtask

  // Both cores stream 4 chars; output must alternate core0/core1 with no loss
  task automatic test_back_to_back();
    logic [7:0] chars [NC][4];
    int sent [NC];
    int got, occ, push, popn;
    do_reset();
    for (int i = 0; i < NC; i++) begin
      sent[i] = 0;
      for (int j = 0; j < 4; j++) chars[i][j] = 8'($urandom);
    end
    got = 0; occ = 0;
    for (int k = 0; k < 300 && got < 8; k++) begin
      for (int i = 0; i < NC; i++) begin
        bus.core_uart_valid[i] = (sent[i] < 4);
        bus.core_uart_ch[i]    = (sent[i] < 4) ? chars[i][sent[i]] : 8'h00;
      end
      bus.uart_out_ready = 1'($urandom);
      #1;
      vectors++;
      if (bus.uart_out_valid !== (occ > 0)) begin
        miscompares++; $display("FAIL uart_valid: cyc=%0d got %b want %b", cyc, bus.uart_out_valid, occ > 0);
      end
      popn = (bus.uart_out_valid && bus.uart_out_ready) ? 1 : 0;
      if (popn == 1) begin
        vectors++;
        if (bus.uart_out_ch !== chars[got % 2][got / 2]) begin
          miscompares++;
          $display("FAIL uart_order: item %0d got %h want %h", got, bus.uart_out_ch, chars[got % 2][got / 2]);
        end
        got++;
      end
      push = 0;
      for (int i = 0; i < NC; i++) if (bus.core_uart_ready[i]) begin sent[i]++; push++; end
      vectors++;
      if (push > 1 || (push == 1 && occ >= UD) || (bus.core_uart_ready & ~bus.core_uart_valid) != '0) begin
        miscompares++;
        $display("FAIL uart_accept: cyc=%0d ready=%b valid=%b occ=%0d", cyc, bus.core_uart_ready, bus.core_uart_valid, occ);
      end
      occ = occ + push - popn;
      tick();
    end
    vectors++;
    if (got != 8) begin
      miscompares++; $display("FAIL uart_count: got %0d chars want 8 within budget", got);
    end
  endtask

  // Pass with chars queued and a stalled sink, then async reset mid-drain
  task automatic test_drain();
    logic [7:0] q [3];
    logic [63:0] code;
    int got;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      q[j] = 8'($urandom);
      bus.core_uart_valid[0] = 1'b1;
      bus.core_uart_ch[0] = q[j];
      tick();
    end
    bus.core_uart_valid[0] = 1'b0;
    bus.core_exit[0] = ALL1;
    bus.core_exit[1] = ALL1;
    tick();
    vectors++;
    if (perf_dump !== 1'b1) begin
      miscompares++; $display("FAIL drain_dump: got %b want 1", perf_dump);
    end
    bus.core_uart_valid[1] = 1'b1;
    bus.core_uart_ch[1] = 8'hA5;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (bus.core_uart_ready !== '0 || bus.uart_out_valid !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_hold: cyc=%0d ready=%b ovld=%b done=%b want 00/1/0", cyc, bus.core_uart_ready, bus.uart_out_valid, done);
      end
      tick();
    end
    bus.uart_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      #1;
      if (bus.uart_out_valid) begin
        vectors++;
        if (bus.uart_out_ch !== q[got]) begin
          miscompares++; $display("FAIL drain_data: item %0d got %h want %h", got, bus.uart_out_ch, q[got]);
        end
        got++;
      end
      tick();
    end
    vectors++;
    if (got != 3 || done !== 1'b0 || bus.uart_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_empty: popped=%0d done=%b ovld=%b want 3/0/0", got, done, bus.uart_out_valid);
    end
    tick();
    vectors++;
    if (done !== 1'b1 || fail !== 1'b0) begin
      miscompares++; $display("FAIL drain_done: done=%b fail=%b want 1/0", done, fail);
    end

    do_reset();
    code = 64'h5;
    for (int j = 0; j < 2; j++) begin
      bus.core_uart_valid[0] = 1'b1;
      bus.core_uart_ch[0] = 8'($urandom);
      tick();
    end
    bus.core_uart_valid[0] = 1'b0;
    bus.core_exit[1] = code;
    tick();
    vectors++;
    if (fail_cause !== 2'd1 || exit_code !== code || perf_dump !== 1'b1) begin
      miscompares++; $display("FAIL drain_fail_latch: cause=%0d code=%h dump=%b want 1/%h/1", fail_cause, exit_code, perf_dump, code);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({done, fail, perf_dump, bus.uart_out_valid} !== 4'b0 || fail_cause !== 2'd0 ||
        fail_core !== 1'b0 || exit_code !== 64'd0 || n_cycles !== '0) begin
      miscompares++;
      $display("FAIL async_reset: done=%b fail=%b dump=%b ovld=%b cause=%0d core=%0d code=%h ncyc=%0d want all 0",
               done, fail, perf_dump, bus.uart_out_valid, fail_cause, fail_core, exit_code, n_cycles);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_exit_err();
    test_stuck();
    test_max_cycles();
    test_perf_clean();
    test_back_to_back();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
